// File: rtl/multicycle_control_unit_if.sv
// Control-unit <-> datapath bundle.
//   master : control unit side (takes opcode/flags/handshake, drives strobes)
//   slave  : datapath side
// Signals: OPCODE, ZERO, MEM_READY toward the unit; IRWrite, PCWrite, PCSrc,
// RegDst, ALUSrc, ALUOp, MemToReg, RegWrite, MemRead, MemWrite, Illegal,
// State back to the datapath.
interface multicycle_control_unit_if #(
  parameter int OPCODE_W = 4,
  parameter int ALUOP_W  = 2
);
  logic [OPCODE_W-1:0] OPCODE;
  logic                ZERO;
  logic                MEM_READY;
  logic                IRWrite, PCWrite, RegDst, ALUSrc;
  logic                MemToReg, RegWrite, MemRead, MemWrite;
  logic [1:0]          PCSrc;
  logic [ALUOP_W-1:0]  ALUOp;
  logic                Illegal;
  logic [2:0]          State;

  modport master (
    input  OPCODE, ZERO, MEM_READY,
    output IRWrite, PCWrite, RegDst, ALUSrc, MemToReg, RegWrite,
           MemRead, MemWrite, PCSrc, ALUOp, Illegal, State
  );
  modport slave (
    output OPCODE, ZERO, MEM_READY,
    input  IRWrite, PCWrite, RegDst, ALUSrc, MemToReg, RegWrite,
           MemRead, MemWrite, PCSrc, ALUOp, Illegal, State
  );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multicycle CPU control FSM: FETCH -> DECODE -> EXEC -> [MEM] -> [WB] -> FETCH.
// Ports: CLK, RESET_N (async active-low), bus (multicycle_control_unit_if.master).
// Optional jump instruction (opcode 0101) is enabled by defining CU_JUMP_EN.
module multicycle_control_unit #(
  parameter int OPCODE_W = 4,
  parameter int ALUOP_W  = 2
) (
  input  logic CLK,
  input  logic RESET_N,
  multicycle_control_unit_if.master bus
);
  typedef enum logic [2:0] {
    FETCH = 3'd0, DECODE = 3'd1, EXEC = 3'd2, MEM = 3'd3, WB = 3'd4
  } state_t;

  localparam logic [OPCODE_W-1:0] OP_I   = OPCODE_W'(4'b0001);
  localparam logic [OPCODE_W-1:0] OP_LS  = OPCODE_W'(4'b0010);
  localparam logic [OPCODE_W-1:0] OP_SS  = OPCODE_W'(4'b0011);
  localparam logic [OPCODE_W-1:0] OP_BEQ = OPCODE_W'(4'b0100);
  localparam logic [OPCODE_W-1:0] OP_R   = OPCODE_W'(4'b0110);
`ifdef CU_JUMP_EN
  localparam logic [OPCODE_W-1:0] OP_J   = OPCODE_W'(4'b0101);
`endif

  localparam logic [ALUOP_W-1:0] ALU_ADD = '0;
  localparam logic [ALUOP_W-1:0] ALU_SUB = ALUOP_W'(2'b01);
  localparam logic [ALUOP_W-1:0] ALU_FN  = ALUOP_W'(2'b10);

  state_t              state, nextState;
  logic [OPCODE_W-1:0] opReg;

  logic               irWrite, pcWrite, regDst, aluSrc, memToReg, regWrite;
  logic               memRead, memWrite, illegal;
  logic [1:0]         pcSrc;
  logic [ALUOP_W-1:0] aluOp;

  function automatic logic isLegal(input logic [OPCODE_W-1:0] op);
    logic ok;
    ok = (op == OP_R) || (op == OP_I) || (op == OP_LS) ||
         (op == OP_SS) || (op == OP_BEQ);
`ifdef CU_JUMP_EN
    ok = ok || (op == OP_J);
`endif
    return ok;
  endfunction

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state <= FETCH;
      opReg <= '0;
    end else begin
      state <= nextState;
      if (state == DECODE) opReg <= bus.OPCODE;
    end
  end

  always_comb begin
    nextState = state;
    irWrite   = 1'b0;
    pcWrite   = 1'b0;
    regDst    = 1'b0;
    aluSrc    = 1'b0;
    memToReg  = 1'b0;
    regWrite  = 1'b0;
    memRead   = 1'b0;
    memWrite  = 1'b0;
    illegal   = 1'b0;
    pcSrc     = 2'b00;
    aluOp     = ALU_ADD;
    unique case (state)
      FETCH: begin
        memRead = 1'b1;
        if (bus.MEM_READY) begin
          irWrite   = 1'b1;
          pcWrite   = 1'b1;
          nextState = DECODE;
        end
      end
      // Legality is judged on the live opcode; the latched copy drives EXEC on.
      DECODE: begin
        if (isLegal(bus.OPCODE)) nextState = EXEC;
        else begin
          illegal   = 1'b1;
          nextState = FETCH;
        end
      end
      EXEC: begin
        nextState = FETCH;
        if (opReg == OP_R) begin
          aluOp     = ALU_FN;
          nextState = WB;
        end else if (opReg == OP_I) begin
          aluSrc    = 1'b1;
          nextState = WB;
        end else if (opReg == OP_LS || opReg == OP_SS) begin
          aluSrc    = 1'b1;
          nextState = MEM;
        end else if (opReg == OP_BEQ) begin
          aluOp   = ALU_SUB;
          pcSrc   = 2'b01;
          pcWrite = bus.ZERO;
        end
`ifdef CU_JUMP_EN
        else if (opReg == OP_J) begin
          pcSrc   = 2'b10;
          pcWrite = 1'b1;
        end
`endif
      end
      MEM: begin
        memRead  = (opReg == OP_LS);
        memWrite = (opReg == OP_SS);
        if (bus.MEM_READY) nextState = (opReg == OP_LS) ? WB : FETCH;
      end
      WB: begin
        regWrite  = 1'b1;
        regDst    = (opReg == OP_R);
        memToReg  = (opReg == OP_LS);
        nextState = FETCH;
      end
      default: nextState = FETCH;
    endcase
  end

  // Reset forces every strobe low immediately, even though FETCH would
  // otherwise assert MemRead.
  always_comb begin
    bus.IRWrite  = RESET_N & irWrite;
    bus.PCWrite  = RESET_N & pcWrite;
    bus.RegDst   = RESET_N & regDst;
    bus.ALUSrc   = RESET_N & aluSrc;
    bus.MemToReg = RESET_N & memToReg;
    bus.RegWrite = RESET_N & regWrite;
    bus.MemRead  = RESET_N & memRead;
    bus.MemWrite = RESET_N & memWrite;
    bus.Illegal  = RESET_N & illegal;
    bus.PCSrc    = RESET_N ? pcSrc : 2'b00;
    bus.ALUOp    = RESET_N ? aluOp : '0;
    bus.State    = RESET_N ? state : 3'd0;
  end
endmodule

// File: tb/tb_multicycle_control_unit.sv
module tb_multicycle_control_unit;
  logic CLK, RESET_N;

  multicycle_control_unit_if #(.OPCODE_W(4), .ALUOP_W(2)) bus ();
  multicycle_control_unit #(.OPCODE_W(4), .ALUOP_W(2)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .bus(bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Packed observation: [15:13] State, 12 IRWrite, 11 PCWrite, [10:9] PCSrc,
  // 8 RegDst, 7 ALUSrc, 6 MemToReg, 5 RegWrite, 4 MemRead, 3 MemWrite,
  // [2:1] ALUOp, 0 Illegal
  localparam logic [15:0] IR  = 16'h1000, PCW = 16'h0800, PBR = 16'h0200,
                          PJ  = 16'h0400, RD  = 16'h0100, AS  = 16'h0080,
                          MTR = 16'h0040, RW  = 16'h0020, MR  = 16'h0010,
                          MW  = 16'h0008, SUB = 16'h0002, FN  = 16'h0004,
                          ILL = 16'h0001;
  localparam logic [15:0] S0 = 16'h0000, S1 = 16'h2000, S2 = 16'h4000,
                          S3 = 16'h6000, S4 = 16'h8000;

  typedef struct {
    logic        rstN;
    logic [3:0]  op;
    logic        zero;
    logic        rdy;
    logic [15:0] exp;
    string       nm;
  } vec_t;

  vec_t tbl[$];
  int checks = 0, errors = 0;
  logic [15:0] act;

  assign act = {bus.State, bus.IRWrite, bus.PCWrite, bus.PCSrc, bus.RegDst,
                bus.ALUSrc, bus.MemToReg, bus.RegWrite, bus.MemRead,
                bus.MemWrite, bus.ALUOp, bus.Illegal};

  task automatic add(input logic r, input logic [3:0] op, input logic z,
                     input logic rdy, input logic [15:0] e, input string nm);
    vec_t v;
    v.rstN = r; v.op = op; v.zero = z; v.rdy = rdy; v.exp = e; v.nm = nm;
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Start in FETCH with MEM_READY=1; count edges until State is FETCH again.
  task automatic lat(input logic [3:0] op, input int expN, input string nm);
    int n;
    n = 0;
    @(negedge CLK);
    bus.OPCODE = op; bus.MEM_READY = 1'b1; bus.ZERO = 1'b0;
    do begin
      @(posedge CLK); #1;
      n++;
    end while (bus.State != 3'd0 && n < 20);
    chk(nm, 16'(n), 16'(expN));
  endtask

  initial begin
    RESET_N = 1'b0;
    bus.OPCODE = 4'b0; bus.ZERO = 1'b0; bus.MEM_READY = 1'b0;

    add(0, 4'h0, 0, 0, 16'h0000,                 "reset_all_zero");
    // R-type; opcode and MEM_READY wiggled in EXEC must not matter
    add(1, 4'h0, 0, 1, S0|MR|IR|PCW,             "r_fetch");
    add(1, 4'h6, 0, 0, S1,                       "r_decode");
    add(1, 4'hF, 0, 1, S2|FN,                    "r_exec");
    add(1, 4'hF, 0, 1, S4|RW|RD,                 "r_wb");
    add(1, 4'h0, 0, 0, S0|MR,                    "fetch_wait");
    // I-type
    add(1, 4'h0, 0, 1, S0|MR|IR|PCW,             "i_fetch");
    add(1, 4'h1, 0, 0, S1,                       "i_decode");
    add(1, 4'h1, 0, 0, S2|AS,                    "i_exec");
    add(1, 4'h1, 0, 0, S4|RW,                    "i_wb");
    // LS with two wait cycles: 7 cycles
    add(1, 4'h0, 0, 1, S0|MR|IR|PCW,             "ls_fetch");
    add(1, 4'h2, 0, 0, S1,                       "ls_decode");
    add(1, 4'h2, 0, 0, S2|AS,                    "ls_exec");
    add(1, 4'h2, 0, 0, S3|MR,                    "ls_mem_w1");
    add(1, 4'h2, 0, 0, S3|MR,                    "ls_mem_w2");
    add(1, 4'h2, 0, 1, S3|MR,                    "ls_mem_done");
    add(1, 4'h2, 0, 0, S4|RW|MTR,                "ls_wb");
    // BEQ taken / not taken
    add(1, 4'h0, 0, 1, S0|MR|IR|PCW,             "beq1_fetch");
    add(1, 4'h4, 0, 0, S1,                       "beq1_decode");
    add(1, 4'h4, 1, 0, S2|SUB|PBR|PCW,           "beq1_exec_taken");
    add(1, 4'h0, 0, 1, S0|MR|IR|PCW,             "beq0_fetch");
    add(1, 4'h4, 0, 0, S1,                       "beq0_decode");
    add(1, 4'h4, 0, 0, S2|SUB|PBR,               "beq0_exec_not_taken");
    // illegal opcode, then jump opcode
    add(1, 4'h0, 0, 1, S0|MR|IR|PCW,             "ill_fetch");
    add(1, 4'hF, 0, 0, S1|ILL,                   "ill_decode");
    add(1, 4'h0, 0, 1, S0|MR|IR|PCW,             "j_fetch");
`ifdef CU_JUMP_EN
    add(1, 4'h5, 0, 0, S1,                       "j_decode");
    add(1, 4'h5, 0, 0, S2|PJ|PCW,                "j_exec");
`else
    add(1, 4'h5, 0, 0, S1|ILL,                   "j_decode_illegal");
    add(1, 4'h0, 0, 0, S0|MR,                    "j_back_fetch");
`endif
    // SS, reset during MEM wait
    add(1, 4'h0, 0, 1, S0|MR|IR|PCW,             "ss_fetch");
    add(1, 4'h3, 0, 0, S1,                       "ss_decode");
    add(1, 4'h3, 0, 0, S2|AS,                    "ss_exec");
    add(1, 4'h3, 0, 0, S3|MW,                    "ss_mem_wait");
    add(0, 4'h3, 0, 0, 16'h0000,                 "ss_reset_drop");
    add(0, 4'h3, 0, 1, 16'h0000,                 "ss_reset_hold");
    add(1, 4'h3, 0, 0, S0|MR,                    "post_reset_fetch");
    add(1, 4'h3, 0, 1, S0|MR|IR|PCW,             "post_reset_fetch_rdy");
    add(1, 4'h6, 0, 0, S1,                       "post_reset_decode");

    repeat (2) @(posedge CLK);
    foreach (tbl[i]) begin
      @(negedge CLK);
      RESET_N = tbl[i].rstN; bus.OPCODE = tbl[i].op;
      bus.ZERO = tbl[i].zero; bus.MEM_READY = tbl[i].rdy;
      #1;
      chk(tbl[i].nm, act, tbl[i].exp);
    end

    // Reset asserted mid-cycle in EXEC: outputs clear without a clock edge.
    @(posedge CLK); #2;
    RESET_N = 1'b0; #1;
    chk("async_reset_mid_cycle", act, 16'h0000);
    @(negedge CLK); RESET_N = 1'b1;

    // Zero-wait FETCH-to-FETCH latencies
    lat(4'h6, 4, "lat_r");
    lat(4'h1, 4, "lat_i");
    lat(4'h3, 4, "lat_ss");
    lat(4'h2, 5, "lat_ls");
    lat(4'h4, 3, "lat_beq");
    lat(4'hF, 2, "lat_illegal");
`ifdef CU_JUMP_EN
    lat(4'h5, 3, "lat_j");
`else
    lat(4'h5, 2, "lat_j_illegal");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
